// File: rtl/key_event_fifo.sv
// Keyboard event FIFO. It queues debounced key bytes, can filter out release
// codes (8'h00), and latches a sticky overflow flag when an event is lost.
module key_event_fifo #(
   parameter int DEPTH     = 8,
   parameter bit DROP_ZERO = 1'b1
) (
   input  logic                     clk,
   input  logic                     nRST,
   input  logic                     keyReady,
   input  logic [7:0]               savedByte,
   input  logic                     rdReady,
   output logic                     rdValid,
   output logic [7:0]               rdData,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow,
   input  logic                     clearOverflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          overflow_q, overflow_d;

   logic wr_req, rd_fire, wr_fire, drop;

   // Occupancy comes from the counter; equal pointers are ambiguous.
   assign full     = (count_q == DEPTH_C);
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign overflow = overflow_q;
   assign rdValid  = !empty;
   assign rdData   = empty ? 8'h00 : mem[rd_ptr_q];

   always_comb begin
      wr_req  = keyReady && !(DROP_ZERO && (savedByte == 8'h00));
      rd_fire = rdValid && rdReady;
      // A pop in the same cycle frees the slot, so a full FIFO can still accept.
      wr_fire = wr_req && (!full || rd_fire);
      drop    = wr_req && full && !rd_fire;

      wr_ptr_d = wr_fire ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = rd_fire ? rd_ptr_q + PTR_ONE : rd_ptr_q;

      count_d = count_q;
      case ({wr_fire, rd_fire})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      overflow_d = overflow_q;
      if (drop)
         overflow_d = 1'b1;
      else if (clearOverflow)
         overflow_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!nRST) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage has no reset; stale contents are unreachable once pointers clear.
   always_ff @(posedge clk) begin
      if (nRST && wr_fire)
         mem[wr_ptr_q] <= savedByte;
   end

endmodule

// File: tb/tb_key_event_fifo.sv
// Directed bench for key_event_fifo: one default instance plus a
// DROP_ZERO=0 instance sharing the same stimulus.
module tb_key_event_fifo;

   logic       clk;
   logic       nRST;
   logic       keyReady;
   logic [7:0] savedByte;
   logic       rdReady;
   logic       clearOverflow;

   logic       rdValid, full, empty, overflow;
   logic [7:0] rdData;
   logic [3:0] count;

   logic       rdValid_nz, full_nz, empty_nz, overflow_nz;
   logic [7:0] rdData_nz;
   logic [3:0] count_nz;

   int checks = 0;
   int errors = 0;

   key_event_fifo #(.DEPTH(8), .DROP_ZERO(1'b1)) dut (
      .clk(clk), .nRST(nRST), .keyReady(keyReady), .savedByte(savedByte),
      .rdReady(rdReady), .rdValid(rdValid), .rdData(rdData), .count(count),
      .full(full), .empty(empty), .overflow(overflow),
      .clearOverflow(clearOverflow)
   );

   key_event_fifo #(.DEPTH(8), .DROP_ZERO(1'b0)) dut_nz (
      .clk(clk), .nRST(nRST), .keyReady(keyReady), .savedByte(savedByte),
      .rdReady(rdReady), .rdValid(rdValid_nz), .rdData(rdData_nz),
      .count(count_nz), .full(full_nz), .empty(empty_nz),
      .overflow(overflow_nz), .clearOverflow(clearOverflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply inputs, take one clock edge, sample 1 time unit later.
   task automatic step(input logic kr, input logic [7:0] b, input logic rr, input logic clr);
      keyReady      = kr;
      savedByte     = b;
      rdReady       = rr;
      clearOverflow = clr;
      @(posedge clk);
      #1;
      $display("t=%0t kr=%b byte=%h rr=%b clr=%b -> cnt=%0d rdV=%b rdD=%h full=%b ovf=%b",
               $time, kr, b, rr, clr, count, rdValid, rdData, full, overflow);
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      step(1'b1, 8'hAA, 1'b1, 1'b0);
      step(1'b1, 8'hBB, 1'b1, 1'b0);
      nRST = 1'b1;
   endtask

   initial begin
      nRST = 1'b1; keyReady = 1'b0; savedByte = 8'h00; rdReady = 1'b0; clearOverflow = 1'b0;
      @(posedge clk); #1;

      // Reset with keyReady/rdReady active must leave the FIFO empty
      do_reset();
      check("rst_count", {4'h0, count}, 8'h00);
      check("rst_empty", {7'h0, empty}, 8'h01);
      check("rst_full", {7'h0, full}, 8'h00);
      check("rst_rdvalid", {7'h0, rdValid}, 8'h00);
      check("rst_rddata", rdData, 8'h00);
      check("rst_overflow", {7'h0, overflow}, 8'h00);

      // Three writes, no reads; one-cycle latency on first write
      step(1'b1, 8'h41, 1'b0, 1'b0);
      check("lat_rdvalid", {7'h0, rdValid}, 8'h01);
      check("lat_rddata", rdData, 8'h41);
      step(1'b1, 8'h42, 1'b0, 1'b0);
      step(1'b1, 8'h43, 1'b0, 1'b0);
      step(1'b0, 8'hFF, 1'b0, 1'b0);
      check("wr3_count", {4'h0, count}, 8'h03);
      check("wr3_head", rdData, 8'h41);

      // Drain in order
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("rd1_data", rdData, 8'h42);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("rd2_data", rdData, 8'h43);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("rd3_empty", {7'h0, empty}, 8'h01);
      check("rd3_rddata", rdData, 8'h00);
      check("rd3_count", {4'h0, count}, 8'h00);

      // Zero-byte filtering vs. pass-through
      step(1'b1, 8'h00, 1'b0, 1'b0);
      check("zero_drop_count", {4'h0, count}, 8'h00);
      check("zero_drop_rdvalid", {7'h0, rdValid}, 8'h00);
      check("zero_keep_count", {4'h0, count_nz}, 8'h01);
      check("zero_keep_rdvalid", {7'h0, rdValid_nz}, 8'h01);
      check("zero_keep_rddata", rdData_nz, 8'h00);
      do_reset();

      // Fill to full, then overflow
      for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      check("fill_full", {7'h0, full}, 8'h01);
      check("fill_count", {4'h0, count}, 8'h08);
      check("fill_ovf_clear", {7'h0, overflow}, 8'h00);
      step(1'b1, 8'h09, 1'b0, 1'b0);
      check("ovf_count", {4'h0, count}, 8'h08);
      check("ovf_set", {7'h0, overflow}, 8'h01);
      step(1'b0, 8'hFF, 1'b0, 1'b0);
      check("ovf_sticky", {7'h0, overflow}, 8'h01);
      // Drop and clear together: set wins
      step(1'b1, 8'h0A, 1'b0, 1'b1);
      check("ovf_set_wins", {7'h0, overflow}, 8'h01);
      check("ovf_count2", {4'h0, count}, 8'h08);
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("ovf_read_%0d", i), rdData, 8'(i));
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      check("ovf_drained", {7'h0, empty}, 8'h01);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check("ovf_cleared", {7'h0, overflow}, 8'h00);

      // Full + write + read in the same cycle
      for (int i = 0; i < 8; i++) step(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0);
      step(1'b1, 8'h55, 1'b1, 1'b0);
      check("fullrw_count", {4'h0, count}, 8'h08);
      check("fullrw_ovf", {7'h0, overflow}, 8'h00);
      for (int i = 1; i < 8; i++) begin
         check($sformatf("fullrw_read_%0d", i), rdData, 8'h11 + 8'(i));
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      check("fullrw_last", rdData, 8'h55);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("fullrw_empty", {7'h0, empty}, 8'h01);

      // Streaming: continuous write+read, pointers wrap several times
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 8'hA0 + 8'(i), 1'b1, 1'b0);
         check($sformatf("stream_data_%0d", i), rdData, 8'hA0 + 8'(i));
         check($sformatf("stream_count_%0d", i), {4'h0, count}, 8'h01);
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("stream_empty", {7'h0, empty}, 8'h01);

      // keyReady low: savedByte ignored
      step(1'b0, 8'h33, 1'b0, 1'b0);
      check("idle_count", {4'h0, count}, 8'h00);

      // Mid-operation reset discards entries
      for (int i = 0; i < 5; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
      check("pre_rst_count", {4'h0, count}, 8'h05);
      nRST = 1'b0;
      step(1'b0, 8'h00, 1'b0, 1'b0);
      nRST = 1'b1;
      check("midrst_count", {4'h0, count}, 8'h00);
      check("midrst_empty", {7'h0, empty}, 8'h01);
      check("midrst_ovf", {7'h0, overflow}, 8'h00);
      step(1'b1, 8'h7A, 1'b0, 1'b0);
      check("postrst_data", rdData, 8'h7A);
      check("postrst_count", {4'h0, count}, 8'h01);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/key_event_fifo.md
KEY_EVENT_FIFO -- requirements
Module: key_event_fifo

Interface
REQ-001: Parameter DEPTH, default 8, FIFO entry count; SHALL be a power of two and at least 2.
REQ-002: Parameter DROP_ZERO, default 1, when 1 the FIFO discards key events whose byte is 8'h00 (key release).
REQ-003: clk  input  1  clock; all state SHALL update on posedge clk.
REQ-004: nRST  input  1  reset, synchronous, active-low.
REQ-005: keyReady  input  1  one-cycle key-event strobe from the debounced keyboard controller.
REQ-006: savedByte  input  8  key byte, valid in any cycle where keyReady=1.
REQ-007: rdReady  input  1  consumer ready to take the head entry.
REQ-008: rdValid  output  1  head entry available.
REQ-009: rdData  output  8  head entry byte.
REQ-010: count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-011: full  output  1  count==DEPTH.
REQ-012: empty  output  1  count==0.
REQ-013: overflow  output  1  sticky flag, set when an event is dropped because the FIFO is full.
REQ-014: clearOverflow  input  1  clears overflow.

Function
REQ-015: Write request wr SHALL be keyReady && !(DROP_ZERO && savedByte==8'h00); keyReady=0 or a filtered zero byte SHALL change no state.
REQ-016: Read handshake rd SHALL be rdValid && rdReady; rd pops the head entry at the clock edge.
REQ-017: rdValid SHALL equal !empty; rdData SHALL equal the head entry when !empty and 8'h00 when empty.
REQ-018: Write latency SHALL be one cycle: a byte accepted at edge N is visible on rdValid/rdData after edge N; there is no same-cycle bypass when empty.
REQ-019: Entries SHALL be read out in the order they were written.
REQ-020: Read and write pointers SHALL each be $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
REQ-021: count SHALL update as follows: wr only, +1; rd only, -1; wr and rd in the same cycle, unchanged.
REQ-022: When full and wr occur together with rd, the write SHALL be accepted (the pop frees the slot) and overflow SHALL NOT be set.
REQ-023: When full and wr occur without rd, the byte SHALL be dropped, the FIFO contents and count SHALL be unchanged, and overflow SHALL be set to 1 on the next edge.
REQ-024: When empty, wr and rdReady occur together, the byte SHALL be stored and SHALL NOT be popped that cycle (rdValid was 0).
REQ-025: overflow SHALL remain 1 until clearOverflow=1; if an overflow drop and clearOverflow coincide, overflow SHALL be 1 after the edge (set wins).
REQ-026: full and empty SHALL be derived from count, never from pointer equality alone.

Reset
REQ-027: While nRST=0 at posedge clk: pointers=0, count=0, overflow=0; hence rdValid=0, rdData=8'h00, empty=1, full=0.
REQ-028: Reset mid-operation SHALL discard all stored entries; storage contents need not be cleared.
REQ-029: keyReady and rdReady asserted during reset SHALL have no effect.

Verification
REQ-030: Reset, then keyReady pulses with 8'h41, 8'h42, 8'h43, rdReady=0 -> count=3, rdData=8'h41; then rdReady=1 for 3 cycles -> reads 41,42,43 in order, then empty=1, rdData=8'h00.
REQ-031: DROP_ZERO=1, keyReady with savedByte 8'h00 -> count stays 0, rdValid=0; with DROP_ZERO=0 the same stimulus -> count=1, rdData=8'h00, rdValid=1.
REQ-032: DEPTH=8, write 8 bytes 01..08 -> full=1; 9th write 8'h09 with rdReady=0 -> count=8, overflow=1, read order 01..08 with 09 absent; clearOverflow=1 -> overflow=0.
REQ-033: Full, keyReady with 8'h55 and rdReady=1 in the same cycle -> count stays 8, overflow=0, 8'h55 read last.
REQ-034: Write and read for 20 bytes with continuous rdReady=1 -> pointers wrap, output sequence equals input sequence, count never exceeds 1.
REQ-035: With 5 entries stored, assert nRST=0 for one cycle -> count=0, empty=1, overflow=0; next write 8'h7A -> rdData=8'h7A.
